apb_intr_ctrl: RTL
==================

Name: apb_intr_ctrl

Overview:
APB slave interrupt controller that sits directly downstream of the CPU/stimulus model. It consumes APB register transfers plus the raw NMI, IRQ[7:0], Int_IRQ[7:0] and i_bit lines, and detects rising edges into pending registers. It applies per-source enables and fixed priority, then returns I_flag (maskable request), UI_flag (unmaskable request) and an encoded vector readable over APB.

Parameters:
WAIT_STATES, 0, extra ACCESS cycles before pready asserts (0..7)
BASE_ADDR, 8'h00, register block base; offsets below added to it

Ports:
pclk  input  1  clock, all state updates on rising edge
preset  input  1  synchronous active-high reset (one clock; synchronous, active-high reset)
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  1=write, 0=read
paddr  input  8  register address
pwdata  input  8  write data
prdata  output  8  read data, valid when pready=1
pready  output  1  transfer complete
pslverr  output  1  error response, valid with pready
NMI  input  1  non-maskable interrupt source
IRQ  input  8  external interrupt sources
Int_IRQ  input  8  internal interrupt sources
i_bit  input  1  global mask for maskable interrupts (1=masked)
I_flag  output  1  maskable interrupt request to CPU
UI_flag  output  1  unmaskable (NMI) request to CPU
vector  output  8  {valid, src[1:0], 2'b00, idx[2:0]}; src 01=NMI 10=ext 11=int

Behaviour:
- Reset (preset=1 at pclk edge): all registers, prev-sample flops, FSM -> 0; prdata=0, pready=0, pslverr=0, I_flag=0, UI_flag=0, vector=0.
- Registers (offset): 0x00 EXT_EN RW; 0x01 INT_EN RW; 0x02 EXT_PEND R/W1C; 0x03 INT_PEND R/W1C; 0x04 NMI_PEND bit0 R/W1C, bits7:1 read 0; 0x05 VECTOR RO.
- Edge detect: each source keeps a prev flop; pending bit sets on the edge where source=1 and prev=0. Level held high does not re-set after clear.
- Pending is captured regardless of enable; enable gates only requests and vector.
- Same-cycle set and W1C on one bit: set wins (bit stays 1).
- I_flag registered: next = !i_bit & (|(EXT_PEND&EXT_EN) | |(INT_PEND&INT_EN)). Source edge at cycle N -> pending at N+1 -> I_flag at N+2.
- UI_flag registered = NMI_PEND; ignores i_bit and enables.
- Vector (registered, same timing as I_flag), priority: NMI > EXT bit0..7 (bit0 highest) > INT bit0..7. Maskable sources are encoded only when !i_bit; NMI is always encoded. No candidate -> vector=0.
- APB FSM: IDLE -> SETUP (psel&!penable) -> ACCESS (psel&penable); ACCESS counts WAIT_STATES cycles, then drives pready=1 for exactly one cycle and returns to IDLE.
- Register write and W1C take effect on the pready cycle only.
- prdata is driven only on the read pready cycle; it is 0 otherwise.
- pslverr=1 with pready for: unmapped offset (>0x05 or below BASE_ADDR), or write to 0x05. Erroring writes change no state; erroring reads return 0.
- psel dropped mid-transfer: FSM -> IDLE next edge, no pready, no register effect.
- penable without a prior SETUP cycle: ignored, stays IDLE.
- Reset during ACCESS aborts the transfer; pready stays 0.

Optional Feature:
INTR_SYNC_EN: when defined, NMI/IRQ/Int_IRQ/i_bit each pass through a 2-flop synchronizer (reset 0) before edge detect and masking. Source-to-pending latency becomes 3 cycles and I_flag/UI_flag 4 cycles. When undefined, inputs are used directly, with latencies as stated above.

Test Plan:
- Reset then read 0x00..0x05 with WAIT_STATES=0 -> all return 8'h00, pready 2 cycles after SETUP, pslverr=0.
- Write EXT_EN=8'h08, pulse IRQ[3], i_bit=0 -> EXT_PEND=8'h08, I_flag=1 two cycles after edge, vector=8'hC3; write 0x02=8'h08 -> I_flag=0.
- IRQ[3] and Int_IRQ[0] both enabled and pending, with NMI pulsed -> UI_flag=1, vector=8'hA0. Clear NMI_PEND -> vector=8'hC3.
- i_bit=1 with EXT_PEND&EXT_EN nonzero -> I_flag=0, vector=0. Drop i_bit -> I_flag=1 next cycle.
- Read 0x07, then write 0x05 -> pslverr=1 with pready on each, prdata=0, no register change. With WAIT_STATES=3 -> pready 3 cycles later.
- IRQ[1] rises on the same cycle as a W1C of bit1 -> EXT_PEND[1] remains 1.

Source files
------------

// File: rtl/apb_intr_ctrl.sv
// rtl/apb_intr_ctrl.sv - APB interrupt controller with edge-detected pending, enables and priority vector; optional INTR_SYNC_EN input synchronizers
module apb_intr_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [7:0]  BASE_ADDR   = 8'h00
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       NMI,
    input  logic [7:0] IRQ,
    input  logic [7:0] Int_IRQ,
    input  logic       i_bit,
    output logic       I_flag,
    output logic       UI_flag,
    output logic [7:0] vector
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t     state, state_n;
    logic [2:0] wait_cnt, wait_cnt_n;
    logic       done;

    logic       nmi_s, ibit_s;
    logic [7:0] irq_s, int_s;
    logic       nmi_prev, nmi_pend;
    logic [7:0] irq_prev, int_prev, ext_pend, int_pend, ext_en, int_en;
    logic [7:0] ext_clr, int_clr, vector_n, rdata;
    logic       nmi_clr;

    logic [8:0] diff;
    logic [7:0] offset;
    logic       in_range, err, wr_ok, rd_ok;

`ifdef INTR_SYNC_EN
    logic [1:0] nmi_sync, ibit_sync;
    logic [7:0] irq_sync1, irq_sync2, int_sync1, int_sync2;

    // Two-flop synchronizers on every interrupt-side input
    always_ff @(posedge pclk) begin
        if (preset) begin
            nmi_sync  <= 2'b00;
            ibit_sync <= 2'b00;
            irq_sync1 <= 8'h00;
            irq_sync2 <= 8'h00;
            int_sync1 <= 8'h00;
            int_sync2 <= 8'h00;
        end else begin
            nmi_sync  <= {nmi_sync[0], NMI};
            ibit_sync <= {ibit_sync[0], i_bit};
            irq_sync1 <= IRQ;
            irq_sync2 <= irq_sync1;
            int_sync1 <= Int_IRQ;
            int_sync2 <= int_sync1;
        end
    end

    assign nmi_s  = nmi_sync[1];
    assign ibit_s = ibit_sync[1];
    assign irq_s  = irq_sync2;
    assign int_s  = int_sync2;
`else
    assign nmi_s  = NMI;
    assign ibit_s = i_bit;
    assign irq_s  = IRQ;
    assign int_s  = Int_IRQ;
`endif

    // Address decode: 9-bit difference so addresses below the base are caught by the borrow
    assign diff     = {1'b0, paddr} - {1'b0, BASE_ADDR};
    assign offset   = diff[7:0];
    assign in_range = !diff[8] && (offset <= 8'd5);
    assign err      = !in_range || (pwrite && offset == 8'd5);
    assign wr_ok    = done && pwrite && !err;
    assign rd_ok    = done && !pwrite && !err;

    assign ext_clr = (wr_ok && offset == 8'd2) ? pwdata : 8'h00;
    assign int_clr = (wr_ok && offset == 8'd3) ? pwdata : 8'h00;
    assign nmi_clr = wr_ok && offset == 8'd4 && pwdata[0];

    // APB next-state: SETUP must precede ACCESS; ACCESS completes after the wait count
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) state_n = SETUP;
            end
            SETUP: begin
                if (!psel) begin
                    state_n = IDLE;
                end else if (penable) begin
                    state_n    = ACCESS;
                    wait_cnt_n = 3'd0;
                end
            end
            ACCESS: begin
                if (!(psel && penable)) begin
                    state_n = IDLE;
                end else if (wait_cnt == WS) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register read mux
    always_comb begin
        rdata = 8'h00;
        case (offset)
            8'd0:    rdata = ext_en;
            8'd1:    rdata = int_en;
            8'd2:    rdata = ext_pend;
            8'd3:    rdata = int_pend;
            8'd4:    rdata = {7'b0, nmi_pend};
            8'd5:    rdata = vector;
            default: rdata = 8'h00;
        endcase
    end

    // Priority encode: NMI, then external bit0..7, then internal bit0..7 (later overrides win)
    always_comb begin
        vector_n = 8'h00;
        if (!ibit_s) begin
            for (int i = 7; i >= 0; i--) begin
                if (int_pend[i] && int_en[i]) vector_n = {3'b111, 2'b00, 3'(i)};
            end
            for (int i = 7; i >= 0; i--) begin
                if (ext_pend[i] && ext_en[i]) vector_n = {3'b110, 2'b00, 3'(i)};
            end
        end
        if (nmi_pend) vector_n = 8'hA0;
    end

    // APB state register and registered response
    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= 8'h00;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            pready   <= done;
            pslverr  <= done && err;
            prdata   <= rd_ok ? rdata : 8'h00;
        end
    end

    // Edge capture into pending (set beats same-cycle clear), enables, and registered requests
    always_ff @(posedge pclk) begin
        if (preset) begin
            nmi_prev <= 1'b0;
            irq_prev <= 8'h00;
            int_prev <= 8'h00;
            nmi_pend <= 1'b0;
            ext_pend <= 8'h00;
            int_pend <= 8'h00;
            ext_en   <= 8'h00;
            int_en   <= 8'h00;
            I_flag   <= 1'b0;
            UI_flag  <= 1'b0;
            vector   <= 8'h00;
        end else begin
            nmi_prev <= nmi_s;
            irq_prev <= irq_s;
            int_prev <= int_s;
            nmi_pend <= (nmi_pend && !nmi_clr) || (nmi_s && !nmi_prev);
            ext_pend <= (ext_pend & ~ext_clr) | (irq_s & ~irq_prev);
            int_pend <= (int_pend & ~int_clr) | (int_s & ~int_prev);
            if (wr_ok && offset == 8'd0) ext_en <= pwdata;
            if (wr_ok && offset == 8'd1) int_en <= pwdata;
            I_flag   <= !ibit_s && ((|(ext_pend & ext_en)) || (|(int_pend & int_en)));
            UI_flag  <= nmi_pend;
            vector   <= vector_n;
        end
    end
endmodule
